// File: rtl/nor_lab_pkg.sv
// Shared types and the behavioural reference for the NOR-structure logic unit.
package nor_lab_pkg;

    localparam int MAX_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOT_A = 3'd0,
        OP_NOT_B = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_XOR   = 3'd6,
        OP_XNOR  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Operands arrive zero-extended to MAX_WIDTH; callers keep only their low WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] ref_result(input op_e op,
                                                        input logic [MAX_WIDTH-1:0] a,
                                                        input logic [MAX_WIDTH-1:0] b);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        unique case (op)
            OP_NOT_A: r = ~a;
            OP_NOT_B: r = ~b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/nor_cell.sv
// WIDTH-bit gate network built only from 2-input NOR; all eight op results in parallel.
module nor_cell #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic [7:0][WIDTH-1:0] res
);

    logic [WIDTH-1:0] not_a, not_b, nor_ab, and_ab, or_ab, nand_ab;
    logic [WIDTH-1:0] a_only, b_only, xnor_ab, xor_ab;

    assign not_a   = ~(a | a);
    assign not_b   = ~(b | b);
    assign nor_ab  = ~(a | b);
    assign and_ab  = ~(not_a | not_b);
    assign or_ab   = ~(nor_ab | nor_ab);
    assign nand_ab = ~(and_ab | and_ab);

    // a_only = ~a & b and b_only = a & ~b; their NOR is XNOR.
    assign a_only  = ~(a | nor_ab);
    assign b_only  = ~(b | nor_ab);
    assign xnor_ab = ~(a_only | b_only);
    assign xor_ab  = ~(xnor_ab | xnor_ab);

    assign res = {xnor_ab, xor_ab, nor_ab, nand_ab, or_ab, and_ab, not_b, not_a};

endmodule

// File: rtl/nor_logic_unit.sv
// Handshaked NOR-structure logic unit with in-line reference check and an
// exhaustive self-sweep mode that counts structure/reference mismatches.
module nor_logic_unit
    import nor_lab_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sweep_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       out_op,
    output logic             out_sweep,
    output logic             busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int VEC_W = 2 * WIDTH;

    state_e                   state;
    op_e                      sweep_op;
    logic [VEC_W-1:0]         vec;

    logic                     slot_free, accept, sweep_load, load, sweep_go, mismatch;
    op_e                      cur_op;
    logic [WIDTH-1:0]         cur_a, cur_b, struct_y, ref_y;
    logic [7:0][WIDTH-1:0]    cell_res;
    logic [MAX_WIDTH-1:0]     ref_full;

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state == ST_IDLE) && !sweep_start && slot_free;
    assign accept     = in_valid && in_ready;
    assign sweep_go   = (state == ST_IDLE) && sweep_start;
    assign sweep_load = (state == ST_SWEEP) && slot_free;
    assign load       = accept || sweep_load;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_op = op_e'(op);
        cur_a  = a;
        cur_b  = b;
        if (state == ST_SWEEP) begin
            cur_op = sweep_op;
            cur_a  = vec[VEC_W-1:WIDTH];
            cur_b  = vec[WIDTH-1:0];
        end
    end

    nor_cell #(.WIDTH(WIDTH)) u_cell (
        .a   (cur_a),
        .b   (cur_b),
        .res (cell_res)
    );

    assign struct_y = cell_res[cur_op];
    assign ref_full = ref_result(cur_op, MAX_WIDTH'(cur_a), MAX_WIDTH'(cur_b));
    assign ref_y    = ref_full[WIDTH-1:0];
    assign mismatch = (struct_y != ref_y);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
        if (!rst_n) begin
            state      <= ST_IDLE;
            sweep_op   <= OP_NOT_A;
            vec        <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sweep_start) begin
                        state    <= ST_SWEEP;
                        sweep_op <= op_e'(op);
                        vec      <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (sweep_load) begin
                        vec <= vec + VEC_W'(1);
                        if (vec == '1) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            sweep_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            y            <= '0;
            out_op       <= '0;
            out_sweep    <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                y         <= struct_y;
                out_op    <= cur_op;
                out_sweep <= sweep_load;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A sweep start blocks request accepts, so clear and count never coincide.
            if (sweep_go) begin
                mismatch_cnt <= '0;
            end else if (load && mismatch && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nor_logic_unit.sv
// Scoreboard bench: stimulus pushes expected results, per-DUT monitors pop on each handshake.
module tb_nor_logic_unit;

    localparam int W  = 4;
    localparam int W2 = 2;
    localparam int CW = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [2:0] op;
        logic       sweep;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          in_valid, in_ready, sweep_start, out_valid, out_ready;
    logic [2:0]    op, out_op;
    logic [W-1:0]  a, b, y;
    logic          out_sweep, busy, sweep_done;
    logic [CW-1:0] mismatch_cnt;

    logic          in_valid2, in_ready2, sweep_start2, out_valid2, out_ready2;
    logic [2:0]    op2, out_op2;
    logic [W2-1:0] a2, b2, y2;
    logic          out_sweep2, busy2, sweep_done2;
    logic [CW-1:0] mismatch_cnt2;

    nor_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .sweep_start(sweep_start), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_op(out_op), .out_sweep(out_sweep), .busy(busy), .sweep_done(sweep_done),
        .mismatch_cnt(mismatch_cnt)
    );

    nor_logic_unit #(.WIDTH(W2), .CNT_W(CW)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
        .a(a2), .b(b2), .sweep_start(sweep_start2), .out_valid(out_valid2), .out_ready(out_ready2),
        .y(y2), .out_op(out_op2), .out_sweep(out_sweep2), .busy(busy2), .sweep_done(sweep_done2),
        .mismatch_cnt(mismatch_cnt2)
    );

    exp_t q4[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;
    int   n4 = 0, n2 = 0, done4 = 0, done2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("result_expected", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                exp_t e;
                e = q4.pop_front();
                check("y", 32'(y), 32'(e.y));
                check("out_op", 32'(out_op), 32'(e.op));
                check("out_sweep", 32'(out_sweep), 32'(e.sweep));
            end
            n4++;
        end
        if (rst_n && sweep_done) done4++;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            check("result_expected_w2", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                exp_t e;
                e = q2.pop_front();
                check("y_w2", 32'(y2), 32'(e.y));
                check("out_op_w2", 32'(out_op2), 32'(e.op));
                check("out_sweep_w2", 32'(out_sweep2), 32'(e.sweep));
            end
            n2++;
        end
        if (rst_n && sweep_done2) done2++;
    end

    function automatic exp_t mk(input logic [7:0] ey, input logic [2:0] eop, input logic esw);
        exp_t e;
        e.y = ey;
        e.op = eop;
        e.sweep = esw;
        return e;
    endfunction

    // Drives one request; pushes its expected result on the cycle it is accepted.
    task automatic send(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] ey, output int stalls);
        logic accepted;
        accepted = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q4.push_back(mk(8'(ey), o, 1'b0));
                accepted = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("request_accepted", 32'(accepted), 1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] dir_y [8];
        int stalls, total_stalls, base, seen;

        dir_y = '{4'b0011, 4'b0101, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

        rst_n = 1'b0;
        in_valid = 0; sweep_start = 0; out_ready = 1; op = 0; a = 0; b = 0;
        in_valid2 = 0; sweep_start2 = 0; out_ready2 = 1; op2 = 0; a2 = 0; b2 = 0;
        tick(3);

        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_y", 32'(y), 0);
        check("rst_out_op", 32'(out_op), 0);
        check("rst_out_sweep", 32'(out_sweep), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sweep_done", 32'(sweep_done), 0);
        check("rst_mismatch_cnt", 32'(mismatch_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        tick(1);

        // All eight ops back to back on a=1100, b=1010.
        total_stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 4'b1100, 4'b1010, dir_y[i], stalls);
            total_stalls += stalls;
        end
        check("b2b_stalls", 32'(total_stalls), 0);
        tick(2);
        check("b2b_count", 32'(n4), 8);
        check("b2b_mismatch_cnt", 32'(mismatch_cnt), 0);

        // Backpressure: hold out_ready low for 3 cycles after the first result.
        send(3'd2, 4'b1100, 4'b1010, 4'b1000, stalls);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_y_held", 32'(y), 32'(4'b1000));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd3, 4'b1100, 4'b1010, 4'b1110, stalls);
        check("bp_release_stalls", 32'(stalls), 0);
        tick(2);
        check("bp_count", 32'(n4), 10);
        check("bp_queue_empty", 32'(q4.size()), 0);

        // XOR sweep; simultaneous in_valid must lose to sweep_start.
        base = n4;
        for (int v = 0; v < 256; v++)
            q4.push_back(mk(8'(((v >> 4) ^ v) & 15), 3'd6, 1'b1));
        sweep_start = 1'b1; op = 3'd6; in_valid = 1'b1; a = 4'b1111; b = 4'b0000;
        @(negedge clk);
        check("sweep_beats_request", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        sweep_start = 1'b0; in_valid = 1'b0; op = 3'd0;
        check("busy_rises", 32'(busy), 1);
        seen = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            sweep_start = (t == 20);
            @(negedge clk);
            if (sweep_done) begin
                check("busy_low_at_done", 32'(busy), 0);
                seen = 1;
                break;
            end
        end
        check("xor_sweep_done_seen", 32'(seen), 1);
        sweep_start = 1'b0;
        tick(4);
        check("xor_sweep_count", 32'(n4 - base), 256);
        check("xor_sweep_done_pulses", 32'(done4), 1);
        check("xor_queue_empty", 32'(q4.size()), 0);
        check("xor_busy_after", 32'(busy), 0);
        check("xor_mismatch_cnt", 32'(mismatch_cnt), 0);
        check("xor_in_ready_after", 32'(in_ready), 1);

        // Reset during a NOR sweep after 37 results.
        base = n4;
        for (int v = 0; v < 256; v++)
            q4.push_back(mk(8'(~((v >> 4) | v) & 15), 3'd5, 1'b1));
        sweep_start = 1'b1; op = 3'd5;
        tick(1);
        sweep_start = 1'b0;
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (n4 - base >= 37) begin
                seen = 1;
                break;
            end
        end
        check("nor_sweep_reached_37", 32'(seen), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_y", 32'(y), 0);
        check("mid_rst_out_op", 32'(out_op), 0);
        check("mid_rst_out_sweep", 32'(out_sweep), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_sweep_done", 32'(sweep_done), 0);
        check("mid_rst_mismatch_cnt", 32'(mismatch_cnt), 0);
        q4.delete();
        tick(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
        send(3'd7, 4'b0000, 4'b0000, 4'b1111, stalls);
        tick(2);
        check("post_rst_queue_empty", 32'(q4.size()), 0);

        // WIDTH=2 AND sweep with random out_ready.
        for (int v = 0; v < 16; v++)
            q2.push_back(mk(8'((v >> 2) & v & 3), 3'd2, 1'b1));
        sweep_start2 = 1'b1; op2 = 3'd2;
        tick(1);
        sweep_start2 = 1'b0;
        seen = 0;
        for (int t = 0; t < 300; t++) begin
            out_ready2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sweep_done2) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("w2_sweep_done_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        out_ready2 = 1'b1;
        tick(4);
        check("w2_sweep_count", 32'(n2), 16);
        check("w2_done_pulses", 32'(done2), 1);
        check("w2_queue_empty", 32'(q2.size()), 0);
        check("w2_mismatch_cnt", 32'(mismatch_cnt2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nor_logic_unit.md
# nor_logic_unit

Parametrised, clocked successor to the team's NOR-only gate derivations: a WIDTH-bit bitwise logic unit. Every result is built only from 2-input NOR cells and is checked in-line against a behavioural reference. It accepts operand/op requests over a valid/ready handshake and returns registered results. It also has a self-sweep mode that enumerates every operand pair for one op and counts structural-vs-reference mismatches. It sits in the lab datapath as the reusable gate-evaluation and self-check engine.

## Interface
Parameters:
- WIDTH, 4: operand and result width in bits (1..8).
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op  in  3  0 NOT_A, 1 NOT_B, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
- a, b  in  WIDTH  operands.
- sweep_start  in  1  single-cycle pulse; starts a sweep of `op`.
- out_valid  out  1  result register holds data.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- y  out  WIDTH  NOR-structure result.
- out_op  out  3  op of the current result.
- out_sweep  out  1  result came from a sweep.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse at the end of a sweep.
- mismatch_cnt  out  CNT_W  saturating count of structure/reference mismatches.

## Operation
- Ops are derived only from NOR:
  - NOT = nor(x,x).
  - AND = nor(¬a,¬b).
  - OR = nor(nor(a,b),nor(a,b)).
  - NAND = nor(AND,AND).
  - XNOR = nor(nor(a,n),nor(b,n)), where n = nor(a,b).
  - XOR = nor(XNOR,XNOR).
- The reference is behavioural (~a, &, |, ^).
- in_ready = (state==IDLE) && !sweep_start && (!out_valid || out_ready).
- On accept, the result register loads y, out_op and out_sweep=0, and sets out_valid.
- out_valid clears on out_ready unless a new result loads in the same cycle.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP on sweep_start. This latches op, clears mismatch_cnt and vector counter vec=0, and sets busy=1. sweep_start beats a simultaneous in_valid.
  - SWEEP: each cycle the output slot is free (!out_valid || out_ready), load the result of {a,b}=vec with out_sweep=1, then vec++. Stalls hold vec.
  - SWEEP → DONE after loading vec = 2^(2·WIDTH)−1.
  - DONE: sweep_done=1 and busy=0 for one cycle, then → IDLE.
- sweep_start outside IDLE is ignored.
- Each load compares structural y with the reference. On mismatch, mismatch_cnt++, saturating at 2^CNT_W−1.
- Reset (any time, including mid-sweep) returns to IDLE and clears every register. Nothing is drained.

## Timing
- Reset values: out_valid 0, y 0, out_op 0, out_sweep 0, busy 0, sweep_done 0, mismatch_cnt 0, in_ready 1 (once rst_n is high and sweep_start is low).
- Latency: 1 cycle from accept (or sweep issue) to out_valid/y.
- Throughput: 1 result per cycle with out_ready held high.
- A sweep under no backpressure takes 2^(2·WIDTH) issue cycles plus 1 DONE cycle. busy rises the cycle after sweep_start.
- mismatch_cnt updates in the same cycle as the corresponding out_valid load.
- y, out_op and out_sweep are stable while out_valid && !out_ready.

## Structure
- Package nor_lab_pkg holds:
  - the op_e enum (the 8 codes above);
  - the FSM state enum;
  - a function that returns the behavioural reference for (op,a,b).
- Sub-module nor_cell: WIDTH-bit, purely NOR gate-level. Produces all eight op results in parallel, and the top muxes by op.
- The top holds the FSM, vec counter, result register, comparator and counter.

## Test plan
- WIDTH=4, a=1100, b=1010, ops 0..7 back-to-back with out_ready=1 → y = 0011, 0101, 1000, 1110, 0111, 0001, 0110, 1001 on consecutive cycles, mismatch_cnt=0.
- Backpressure: out_ready=0 for 3 cycles after the first result → in_ready=0, y held. Release → next result follows in 1 cycle, none lost or duplicated.
- Sweep op=6 (XOR), WIDTH=4, out_ready=1 → exactly 256 results, out_sweep=1. The last result is a=b=1111, y=0000. sweep_done pulses once, busy falls, mismatch_cnt=0.
- sweep_start and in_valid in the same IDLE cycle → sweep starts and the request is not accepted. A second sweep_start mid-sweep is ignored (still 256 results).
- rst_n low after 37 sweep results → all outputs at reset values immediately. After release: IDLE, in_ready=1.
- Random out_ready toggling during a WIDTH=2 sweep → 16 results in vec order, no gaps.
